// File: rtl/pe_part_sum_collect_rx.sv
// pe_part_sum_collect_rx
// Receive side of the PE partial-sum exchange for the V computation stage.
// Packets from the network interface carry a rank index in the low address
// bits; each one is added (saturating) into that rank's accumulator. When
// every valid rank has received num_src contributions, fin_rx_part_sum
// pulses for one cycle and the block drops back to idle. Accumulators stay
// readable in idle until the next start.

module pe_part_sum_collect_rx #(
    parameter int DATA_WIDTH        = 16,
    parameter int RANK_WIDTH        = 6,
    parameter int ROUTER_ADDR_WIDTH = 8,
    parameter int SRC_WIDTH         = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [RANK_WIDTH-1:0]        rank_no,
    input  logic [SRC_WIDTH-1:0]         num_src,
    input  logic                         recv_valid,
    input  logic [ROUTER_ADDR_WIDTH-1:0] recv_addr,
    input  logic [DATA_WIDTH-1:0]        recv_data,
    output logic                         recv_rdy,
    input  logic                         acc_read_en,
    input  logic [RANK_WIDTH-1:0]        acc_read_addr,
    output logic [DATA_WIDTH-1:0]        acc_read_data,
    output logic                         busy,
    output logic                         fin_rx_part_sum,
    output logic                         rx_err
);

    localparam int DEPTH       = 1 << RANK_WIDTH;
    // Wide enough for the full rank_no * num_src product.
    localparam int TOTAL_WIDTH = RANK_WIDTH + SRC_WIDTH;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [RANK_WIDTH-1:0]   rank_no_q, rank_no_d;
    logic [SRC_WIDTH-1:0]    num_src_q, num_src_d;
    logic [DATA_WIDTH-1:0]   acc_q [DEPTH];
    logic [DATA_WIDTH-1:0]   acc_d [DEPTH];
    logic [SRC_WIDTH-1:0]    cnt_q [DEPTH];
    logic [SRC_WIDTH-1:0]    cnt_d [DEPTH];
    logic [TOTAL_WIDTH-1:0]  total_q, total_d;
    logic                    fin_q, fin_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   rd_data_q, rd_data_d;

    logic [RANK_WIDTH-1:0]   pkt_idx;
    logic                    pkt_hi_bad;
    logic                    pkt_accept;
    logic                    pkt_drop;
    logic [TOTAL_WIDTH-1:0]  total_target;
    logic [TOTAL_WIDTH-1:0]  total_inc;
    logic [DATA_WIDTH:0]     sum_wide;
    logic [DATA_WIDTH-1:0]   sum_sat;

    // Handshake and status outputs are decoded straight from registered state.
    assign recv_rdy        = (state_q == ST_COLLECT);
    assign busy            = (state_q == ST_COLLECT);
    assign fin_rx_part_sum = fin_q;
    assign rx_err          = err_q;
    assign acc_read_data   = rd_data_q;

    // Packet decode: target index, drop reasons and the saturating sum.
    always_comb begin
        pkt_idx      = recv_addr[RANK_WIDTH-1:0];
        pkt_hi_bad   = |recv_addr[ROUTER_ADDR_WIDTH-1:RANK_WIDTH];
        pkt_accept   = recv_valid && recv_rdy && !start;
        pkt_drop     = pkt_hi_bad
                       || (pkt_idx >= rank_no_q)
                       || (cnt_q[pkt_idx] == num_src_q);
        total_target = TOTAL_WIDTH'(rank_no_q) * TOTAL_WIDTH'(num_src_q);
        total_inc    = total_q + TOTAL_WIDTH'(1);
        sum_wide     = {acc_q[pkt_idx][DATA_WIDTH-1], acc_q[pkt_idx]}
                       + {recv_data[DATA_WIDTH-1], recv_data};
        if (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1]) begin
            sum_sat = sum_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                           : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            sum_sat = sum_wide[DATA_WIDTH-1:0];
        end
    end

    // Next-state logic: start handling, packet accumulation and completion.
    always_comb begin
        state_d   = state_q;
        rank_no_d = rank_no_q;
        num_src_d = num_src_q;
        total_d   = total_q;
        err_d     = err_q;
        fin_d     = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            acc_d[k] = acc_q[k];
            cnt_d[k] = cnt_q[k];
        end

        // Reads see the pre-update value when they collide with a write.
        rd_data_d = acc_read_en ? acc_q[acc_read_addr] : rd_data_q;

        if (start) begin
            rank_no_d = rank_no;
            num_src_d = num_src;
            total_d   = '0;
            err_d     = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                acc_d[k] = '0;
                cnt_d[k] = '0;
            end
            if ((rank_no == '0) || (num_src == '0)) begin
                state_d = ST_IDLE;
                fin_d   = 1'b1;
            end else begin
                state_d = ST_COLLECT;
            end
        end else if (pkt_accept) begin
            if (pkt_drop) begin
                err_d = 1'b1;
            end else begin
                acc_d[pkt_idx] = sum_sat;
                cnt_d[pkt_idx] = cnt_q[pkt_idx] + SRC_WIDTH'(1);
                total_d        = total_inc;
                if (total_inc == total_target) begin
                    state_d = ST_IDLE;
                    fin_d   = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset that clears the whole bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rank_no_q <= '0;
            num_src_q <= '0;
            total_q   <= '0;
            fin_q     <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                acc_q[k] <= '0;
                cnt_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            rank_no_q <= rank_no_d;
            num_src_q <= num_src_d;
            total_q   <= total_d;
            fin_q     <= fin_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
            for (int k = 0; k < DEPTH; k++) begin
                acc_q[k] <= acc_d[k];
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pe_part_sum_collect_rx.sv
// tb_pe_part_sum_collect_rx
// Directed scenarios followed by a randomized phase. A behavioural model of
// the collection (integer arrays, plain saturating arithmetic) predicts every
// output after each clock edge.

module tb_pe_part_sum_collect_rx;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  rank_no;
    logic [5:0]  num_src;
    logic        recv_valid;
    logic [7:0]  recv_addr;
    logic [15:0] recv_data;
    logic        recv_rdy;
    logic        acc_read_en;
    logic [5:0]  acc_read_addr;
    logic [15:0] acc_read_data;
    logic        busy;
    logic        fin_rx_part_sum;
    logic        rx_err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_collect;
    int m_rank, m_src, m_total, m_rd;
    bit m_fin, m_err;
    int m_acc [64];
    int m_cnt [64];

    pe_part_sum_collect_rx dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .rank_no         (rank_no),
        .num_src         (num_src),
        .recv_valid      (recv_valid),
        .recv_addr       (recv_addr),
        .recv_data       (recv_data),
        .recv_rdy        (recv_rdy),
        .acc_read_en     (acc_read_en),
        .acc_read_addr   (acc_read_addr),
        .acc_read_data   (acc_read_data),
        .busy            (busy),
        .fin_rx_part_sum (fin_rx_part_sum),
        .rx_err          (rx_err)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int clampSum(int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic modelClear();
        m_total = 0;
        for (int k = 0; k < 64; k++) begin
            m_acc[k] = 0;
            m_cnt[k] = 0;
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge
    task automatic modelEdge();
        int nrd;
        int idx;
        nrd = acc_read_en ? m_acc[acc_read_addr] : m_rd;
        if (rst) begin
            m_collect = 0; m_rank = 0; m_src = 0;
            m_fin = 0; m_err = 0; nrd = 0;
            modelClear();
        end else begin
            m_fin = 0;
            if (start) begin
                m_rank = int'(rank_no);
                m_src  = int'(num_src);
                m_err  = 0;
                modelClear();
                if (m_rank == 0 || m_src == 0) begin
                    m_collect = 0;
                    m_fin = 1;
                end else begin
                    m_collect = 1;
                end
            end else if (recv_valid && m_collect) begin
                idx = int'(recv_addr) % 64;
                if (int'(recv_addr) >= 64 || idx >= m_rank || m_cnt[idx] == m_src) begin
                    m_err = 1;
                end else begin
                    m_acc[idx] = clampSum(m_acc[idx] + int'($signed(recv_data)));
                    m_cnt[idx]++;
                    m_total++;
                    if (m_total == m_rank * m_src) begin
                        m_collect = 0;
                        m_fin = 1;
                    end
                end
            end
        end
        m_rd = nrd;
    endtask

    task automatic checkVal(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput();
        logic [15:0] exp_rd;
        exp_rd = 16'(m_rd);
        checkVal("recv_rdy", {31'b0, recv_rdy}, {31'b0, m_collect});
        checkVal("busy", {31'b0, busy}, {31'b0, m_collect});
        checkVal("fin", {31'b0, fin_rx_part_sum}, {31'b0, m_fin});
        checkVal("rx_err", {31'b0, rx_err}, {31'b0, m_err});
        checkVal("acc_read_data", {16'b0, acc_read_data}, {16'b0, exp_rd});
    endtask

    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic applyStimulus(bit st, int rk, int sr, bit v, int addr, int data);
        start      = st;
        rank_no    = 6'(rk);
        num_src    = 6'(sr);
        recv_valid = v;
        recv_addr  = 8'(addr);
        recv_data  = 16'(data);
        tick();
        start      = 1'b0;
        recv_valid = 1'b0;
    endtask

    task automatic readEntry(int a, int exp, string tag);
        start         = 1'b0;
        recv_valid    = 1'b0;
        acc_read_en   = 1'b1;
        acc_read_addr = 6'(a);
        tick();
        acc_read_en   = 1'b0;
        checkVal(tag, {16'b0, acc_read_data}, {16'b0, 16'(exp)});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rank_no = '0; num_src = '0;
        recv_valid = 1'b0; recv_addr = '0; recv_data = '0;
        acc_read_en = 1'b0; acc_read_addr = '0;
        m_rd = 0;
        #1;
        tick();
        tick();
        rst = 1'b0;
        checkVal("reset_rdy", {31'b0, recv_rdy}, 32'd0);
        checkVal("reset_busy", {31'b0, busy}, 32'd0);
        checkVal("reset_rd", {16'b0, acc_read_data}, 32'd0);
        tick();

        // Normal collection
        applyStimulus(1, 4, 2, 0, 0, 0);
        checkVal("normal_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, i, 10 * (i + 1));
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, i, i + 1);
        checkVal("normal_no_early_fin", {31'b0, fin_rx_part_sum}, 32'd0);
        applyStimulus(0, 0, 0, 1, 3, 4);
        checkVal("normal_fin", {31'b0, fin_rx_part_sum}, 32'd1);
        checkVal("normal_rdy_in_fin", {31'b0, recv_rdy}, 32'd0);
        for (int i = 0; i < 4; i++) readEntry(i, 11 * (i + 1), "normal_read");

        // Same-index back-to-back
        applyStimulus(1, 1, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, -5);
        applyStimulus(0, 0, 0, 1, 0, 7);
        applyStimulus(0, 0, 0, 1, 0, 100);
        checkVal("b2b_fin", {31'b0, fin_rx_part_sum}, 32'd1);
        readEntry(0, 102, "b2b_read");

        // Saturation, both directions
        applyStimulus(1, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 30000);
        applyStimulus(0, 0, 0, 1, 0, 10000);
        readEntry(0, 32767, "sat_pos");
        applyStimulus(1, 1, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, -30000);
        applyStimulus(0, 0, 0, 1, 0, -10000);
        readEntry(0, -32768, "sat_neg");

        // Drops
        applyStimulus(1, 2, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 8'h05, 9);
        applyStimulus(0, 0, 0, 1, 8'h40, 9);
        applyStimulus(0, 0, 0, 1, 0, 50);
        applyStimulus(0, 0, 0, 1, 0, 60);
        checkVal("drop_err", {31'b0, rx_err}, 32'd1);
        checkVal("drop_no_fin", {31'b0, fin_rx_part_sum}, 32'd0);
        applyStimulus(0, 0, 0, 1, 1, 3);
        checkVal("drop_fin", {31'b0, fin_rx_part_sum}, 32'd1);
        readEntry(0, 50, "drop_acc0");

        // Restart mid-collection
        applyStimulus(1, 4, 2, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 5);
        applyStimulus(0, 0, 0, 1, 1, 6);
        applyStimulus(0, 0, 0, 1, 8'h80, 1);
        applyStimulus(0, 0, 0, 1, 2, 7);
        checkVal("restart_err_before", {31'b0, rx_err}, 32'd1);
        applyStimulus(1, 2, 1, 1, 0, 99);
        checkVal("restart_err_clear", {31'b0, rx_err}, 32'd0);
        checkVal("restart_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) readEntry(i, 0, "restart_zero");
        applyStimulus(0, 0, 0, 1, 0, 1);
        applyStimulus(0, 0, 0, 1, 1, 2);
        checkVal("restart_fin", {31'b0, fin_rx_part_sum}, 32'd1);

        // Reset mid-collection
        applyStimulus(1, 3, 3, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 11);
        acc_read_en = 1'b1; acc_read_addr = 6'd0;
        applyStimulus(0, 0, 0, 1, 9, 11);
        acc_read_en = 1'b0;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 1, 1, 22);
        rst = 1'b0;
        checkVal("rst_mid_busy", {31'b0, busy}, 32'd0);
        checkVal("rst_mid_err", {31'b0, rx_err}, 32'd0);
        checkVal("rst_mid_rd", {16'b0, acc_read_data}, 32'd0);

        // Degenerate starts
        applyStimulus(1, 0, 3, 0, 0, 0);
        checkVal("degen_fin", {31'b0, fin_rx_part_sum}, 32'd1);
        checkVal("degen_busy", {31'b0, busy}, 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 5);
        checkVal("degen_fin_gone", {31'b0, fin_rx_part_sum}, 32'd0);
        applyStimulus(1, 3, 0, 0, 0, 0);
        checkVal("degen_src0_fin", {31'b0, fin_rx_part_sum}, 32'd1);

        // Randomized phase
        for (int c = 0; c < 1500; c++) begin
            rst           = ($urandom % 300) == 0;
            start         = ($urandom % 30) == 0;
            rank_no       = 6'($urandom_range(0, 5));
            num_src       = 6'($urandom_range(0, 3));
            recv_valid    = ($urandom % 4) != 0;
            recv_addr     = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom_range(0, 5));
            recv_data     = 16'($urandom);
            acc_read_en   = ($urandom % 2) == 0;
            acc_read_addr = 6'($urandom_range(0, 7));
            tick();
        end
        rst = 1'b0; start = 1'b0; recv_valid = 1'b0; acc_read_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
